// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: display data / handshake / pin bundle for seg_scan_mux.
// The master side (status logic) supplies the digits and LOAD; the slave side
// (the scan driver) returns the handshake flags and drives the board pins.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] VALUE;
    logic [NUM_DIGITS-1:0]   DP;
    logic [NUM_DIGITS-1:0]   BLANK;
    logic                    LOAD;
    logic                    LOAD_ACK;
    logic                    BUSY;
    logic                    FRAME_DONE;
    logic [NUM_DIGITS-1:0]   ANODE;
    logic [7:0]              SEG;

    modport master (
        output VALUE, DP, BLANK, LOAD,
        input  LOAD_ACK, BUSY, FRAME_DONE, ANODE, SEG
    );

    modport slave (
        input  VALUE, DP, BLANK, LOAD,
        output LOAD_ACK, BUSY, FRAME_DONE, ANODE, SEG
    );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment driver for NUM_DIGITS hex digits.
// A pending buffer takes LOAD data at any time; it is copied to the shadow
// (displayed) buffer only at the frame boundary, so a frame never tears.
// Each digit slot starts with DEAD_CYCLES of all-anodes-off to stop ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 16384,
    parameter int DEAD_CYCLES = 64
) (
    input logic           CLK,
    input logic           RST_N,
    seg_scan_mux_if.slave bus
);
    localparam int CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IDX_SPAN = 1 << IW;
    localparam logic [CW-1:0]         CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

    // Hex nibble to {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [CW-1:0]           cnt_reg,        cnt_next;
    logic [IW-1:0]           idx_reg,        idx_next;
    logic [4*NUM_DIGITS-1:0] pend_value_reg, pend_value_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg,    pend_dp_next;
    logic [NUM_DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic [4*NUM_DIGITS-1:0] shad_value_reg, shad_value_next;
    logic [NUM_DIGITS-1:0]   shad_dp_reg,    shad_dp_next;
    logic [NUM_DIGITS-1:0]   shad_blank_reg, shad_blank_next;
    logic                    busy_reg,       busy_next;
    logic                    ack_reg,        ack_next;
    logic                    done_reg,       done_next;
    logic [NUM_DIGITS-1:0]   anode_reg,      anode_next;
    logic [7:0]              seg_reg,        seg_next;

    logic                    frame_end;
    logic                    dead;
    int                      cnt_int;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7:0]              digit_seg [IDX_SPAN];

    assign frame_end = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
    assign cnt_int   = int'(cnt_reg);
    assign dead      = (cnt_int < DEAD_CYCLES);

`ifdef LEADING_ZERO_BLANK_EN
    // zero_run[i]: every digit from the top down to i is a 0 with its DP off.
    logic [NUM_DIGITS:0] zero_run;
    assign zero_run[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign zero_run[gi] = zero_run[gi+1] &&
                              (shad_value_reg[4*gi +: 4] == 4'h0) && !shad_dp_reg[gi];
        if (gi == 0) begin : g_keep0
            // The rightmost digit always shows, so an all-zero value reads "0".
            assign lz_blank[gi] = 1'b0;
        end else begin : g_sup
            assign lz_blank[gi] = zero_run[gi];
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Segment image of every digit from the shadow buffer; unused slots stay dark.
    for (genvar gi = 0; gi < IDX_SPAN; gi++) begin : g_digit
        if (gi < NUM_DIGITS) begin : g_real
            assign digit_seg[gi] = (shad_blank_reg[gi] || lz_blank[gi]) ? 8'hFF :
                                   {hex7(shad_value_reg[4*gi +: 4]), ~shad_dp_reg[gi]};
        end else begin : g_pad
            assign digit_seg[gi] = 8'hFF;
        end
    end

    // Next state: scan position, double-buffer handshake and pin image.
    always_comb begin
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = idx_reg;
        pend_value_next = pend_value_reg;
        pend_dp_next    = pend_dp_reg;
        pend_blank_next = pend_blank_reg;
        shad_value_next = shad_value_reg;
        shad_dp_next    = shad_dp_reg;
        shad_blank_next = shad_blank_reg;
        busy_next       = busy_reg;

        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        if (frame_end) begin
            // A LOAD on the boundary cycle is newer than anything pending.
            if (bus.LOAD) begin
                shad_value_next = bus.VALUE;
                shad_dp_next    = bus.DP;
                shad_blank_next = bus.BLANK;
            end else if (busy_reg) begin
                shad_value_next = pend_value_reg;
                shad_dp_next    = pend_dp_reg;
                shad_blank_next = pend_blank_reg;
            end
            busy_next = 1'b0;
        end else if (bus.LOAD) begin
            pend_value_next = bus.VALUE;
            pend_dp_next    = bus.DP;
            pend_blank_next = bus.BLANK;
            busy_next       = 1'b1;
        end

        ack_next   = frame_end && (bus.LOAD || busy_reg);
        done_next  = frame_end;
        anode_next = dead ? '1 : ~(ANODE_ONE << idx_reg);
        seg_next   = dead ? 8'hFF : digit_seg[idx_reg];
    end

    // State and output registers; reset shows a dark display holding value 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            shad_value_reg <= '0;
            shad_dp_reg    <= '0;
            shad_blank_reg <= '0;
            busy_reg       <= 1'b0;
            ack_reg        <= 1'b0;
            done_reg       <= 1'b0;
            anode_reg      <= '1;
            seg_reg        <= 8'hFF;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            pend_value_reg <= pend_value_next;
            pend_dp_reg    <= pend_dp_next;
            pend_blank_reg <= pend_blank_next;
            shad_value_reg <= shad_value_next;
            shad_dp_reg    <= shad_dp_next;
            shad_blank_reg <= shad_blank_next;
            busy_reg       <= busy_next;
            ack_reg        <= ack_next;
            done_reg       <= done_next;
            anode_reg      <= anode_next;
            seg_reg        <= seg_next;
        end
    end

    assign bus.LOAD_ACK   = ack_reg;
    assign bus.BUSY       = busy_reg;
    assign bus.FRAME_DONE = done_reg;
    assign bus.ANODE      = anode_reg;
    assign bus.SEG        = seg_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: checks seg_scan_mux (4 digits, SCAN_DIV 8, dead 2) against a
// frame-position reference model, plus a 1-digit instance for the degenerate scan.
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int S  = 8;
    localparam int D  = 2;
    localparam int FL = N * S;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   ack_count = 0;

    seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();
    seg_scan_mux_if #(.NUM_DIGITS(1)) bus1 ();

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(D)) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus)
    );
    seg_scan_mux #(.NUM_DIGITS(1), .SCAN_DIV(S), .DEAD_CYCLES(D)) dut1 (
        .CLK(clk), .RST_N(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Segment table from the datasheet order 0..F, {a..g} active-low.
    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model: frame position plus displayed / pending buffers.
    int          pos, k1;
    logic [15:0] sh_val, pd_val;
    logic [3:0]  sh_dp, sh_bl, pd_dp, pd_bl;
    logic        m_busy;
    logic [3:0]  e_anode;
    logic [7:0]  e_seg, e1_seg;
    logic        e_ack, e_done, e_busy, e1_anode, e1_done;

    function automatic logic [7:0] digit_image(int d, logic [15:0] v, logic [3:0] dp, logic [3:0] bl);
        if (bl[d]) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0) begin
            bit lead = 1'b1;
            for (int j = d; j < N; j++)
                if (v[4*j +: 4] != 4'h0 || dp[j]) lead = 1'b0;
            if (lead) return 8'hFF;
        end
`endif
        return {seg_tab[v[4*d +: 4]], ~dp[d]};
    endfunction

    task automatic model_reset();
        pos = 0; k1 = 0;
        sh_val = '0; sh_dp = '0; sh_bl = '0;
        pd_val = '0; pd_dp = '0; pd_bl = '0;
        m_busy = 1'b0;
        e_anode = 4'hF; e_seg = 8'hFF; e_ack = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        e1_anode = 1'b1; e1_seg = 8'hFF; e1_done = 1'b0;
    endtask

    task automatic model_step();
        int  c = pos % S;
        int  d = pos / S;
        int  c1 = k1 % S;
        bit  frame = (pos == FL - 1);
        e_anode = (c < D) ? 4'hF : ~(4'b0001 << d);
        e_seg   = (c < D) ? 8'hFF : digit_image(d, sh_val, sh_dp, sh_bl);
        e_done  = frame;
        e_ack   = frame && (bus.LOAD || m_busy);
        if (frame) begin
            if (bus.LOAD) begin
                sh_val = bus.VALUE; sh_dp = bus.DP; sh_bl = bus.BLANK;
            end else if (m_busy) begin
                sh_val = pd_val; sh_dp = pd_dp; sh_bl = pd_bl;
            end
            m_busy = 1'b0;
        end else if (bus.LOAD) begin
            pd_val = bus.VALUE; pd_dp = bus.DP; pd_bl = bus.BLANK;
            m_busy = 1'b1;
        end
        e_busy = m_busy;
        pos = (pos + 1) % FL;
        e1_anode = (c1 < D);
        e1_seg   = (c1 < D) ? 8'hFF : 8'h03;
        e1_done  = (c1 == S - 1);
        k1++;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        check("anode", 32'(bus.ANODE), 32'(e_anode));
        check("seg", 32'(bus.SEG), 32'(e_seg));
        check("load_ack", 32'(bus.LOAD_ACK), 32'(e_ack));
        check("busy", 32'(bus.BUSY), 32'(e_busy));
        check("frame_done", 32'(bus.FRAME_DONE), 32'(e_done));
        check("n1_anode", 32'(bus1.ANODE), 32'(e1_anode));
        check("n1_seg", 32'(bus1.SEG), 32'(e1_seg));
        check("n1_frame_done", 32'(bus1.FRAME_DONE), 32'(e1_done));
        if (bus.LOAD_ACK) ack_count++;
    endtask

    task automatic run_to_pos(int p);
        for (int i = 0; i < FL && pos != p; i++) tick();
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FL && !ok; i++) begin
            tick();
            if (bus.LOAD_ACK) ok = 1'b1;
        end
    endtask

    task automatic capture_frame(output logic [3:0][7:0] segs, output logic [3:0] seen);
        segs = '1; seen = '0;
        for (int t = 0; t < FL; t++) begin
            tick();
            for (int d = 0; d < N; d++)
                if (bus.ANODE == ~(4'b0001 << d) && !seen[d]) begin
                    seen[d] = 1'b1;
                    segs[d] = bus.SEG;
                end
        end
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] dp, logic [3:0] bl);
        bus.VALUE = v; bus.DP = dp; bus.BLANK = bl; bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
    endtask

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [3:0]       blank;
        logic [3:0][7:0]  seg;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [3:0][7:0] segs;
        logic [3:0]      seen;
        bit              ok;
        int              acks0;

        // Expected images per digit, element [d] = digit d.
        vecs[0] = '{16'h1A2F, 4'b0000, 4'b0000, {8'h9F, 8'h11, 8'h25, 8'h71}};
        vecs[1] = '{16'h3456, 4'b0001, 4'b0100, {8'h0D, 8'hFF, 8'h49, 8'h40}};
        vecs[2] = '{16'hBCDE, 4'b1010, 4'b0000, {8'hC0, 8'h63, 8'h84, 8'h61}};
        vecs[5] = '{16'h9874, 4'b0110, 4'b1001, {8'hFF, 8'h00, 8'h1E, 8'hFF}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[3] = '{16'h0050, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'h49, 8'h03}};
        vecs[4] = '{16'h0000, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
`else
        vecs[3] = '{16'h0050, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h49, 8'h03}};
        vecs[4] = '{16'h0000, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h03, 8'h03}};
`endif

        bus.VALUE = '0; bus.DP = '0; bus.BLANK = '0; bus.LOAD = 1'b0;
        bus1.VALUE = 4'h7; bus1.DP = 1'b1; bus1.BLANK = 1'b0; bus1.LOAD = 1'b0;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;

        // Power-up frame: every digit shows "0" with DP dark.
        capture_frame(segs, seen);
        check("reset_digits_seen", 32'(seen), 32'hF);
        check("reset_digit0", 32'(segs[0]), 32'h03);

        // Table: load mid-frame, wait for the ack, inspect the following frame.
        for (int r = 0; r < 6; r++) begin
            run_to_pos(10);
            do_load(vecs[r].value, vecs[r].dp, vecs[r].blank);
            check($sformatf("v%0d_busy", r), 32'(bus.BUSY), 32'h1);
            wait_ack(ok);
            check($sformatf("v%0d_ack_wait", r), 32'(ok), 32'h1);
            capture_frame(segs, seen);
            check($sformatf("v%0d_seen", r), 32'(seen), 32'hF);
            for (int d = 0; d < N; d++)
                check($sformatf("v%0d_digit%0d", r, d), 32'(segs[d]), 32'(vecs[r].seg[d]));
        end

        // Two loads in one frame: the later wins, one ack only.
        run_to_pos(5);
        acks0 = ack_count;
        do_load(16'h1111, 4'b0000, 4'b0000);
        run_to_pos(20);
        do_load(16'h2222, 4'b0000, 4'b0000);
        wait_ack(ok);
        capture_frame(segs, seen);
        check("double_load_acks", 32'(ack_count - acks0), 32'h1);
        check("double_load_digit0", 32'(segs[0]), 32'h25);
        check("double_load_digit3", 32'(segs[3]), 32'h25);

        // LOAD on the boundary cycle bypasses the pending buffer.
        run_to_pos(FL - 1);
        do_load(16'h3333, 4'b0000, 4'b0000);
        check("bypass_busy", 32'(bus.BUSY), 32'h0);
        check("bypass_ack", 32'(bus.LOAD_ACK), 32'h1);
        capture_frame(segs, seen);
        check("bypass_digit0", 32'(segs[0]), 32'h0D);
        check("bypass_digit2", 32'(segs[2]), 32'h0D);

        // Randomised traffic, with extra weight on boundary-cycle loads.
        for (int i = 0; i < 1200; i++) begin
            bus.VALUE = 16'($urandom);
            bus.DP    = 4'($urandom);
            bus.BLANK = 4'($urandom) & 4'($urandom);
            bus.LOAD  = ($urandom_range(15) == 0) ||
                        (pos == FL - 1 && $urandom_range(3) == 0);
            tick();
        end
        bus.LOAD = 1'b0;

        // Asynchronous reset mid-slot with a capture pending.
        run_to_pos(12);
        do_load(16'hABCD, 4'b1111, 4'b0000);
        tick();
        check("pre_reset_busy", 32'(bus.BUSY), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_anode", 32'(bus.ANODE), 32'hF);
        check("async_seg", 32'(bus.SEG), 32'hFF);
        check("async_busy", 32'(bus.BUSY), 32'h0);
        check("async_n1_anode", 32'(bus1.ANODE), 32'h1);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        capture_frame(segs, seen);
        check("post_reset_seen", 32'(seen), 32'hF);
        for (int d = 0; d < N; d++)
            check($sformatf("post_reset_digit%0d", d), 32'(segs[d]), 32'(vecs[4].seg[d]));
        check("post_reset_acks", 32'(bus.BUSY), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
